// File: rtl/uart_cmd_sequencer.sv
// ============================================================================
// Module  : uart_cmd_sequencer
// Purpose : Frames UART bytes (SYNC, OPCODE, operands, XOR check) into CORDIC
//           commands issued over valid/ready. Optional macro: UART_CMD_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_sequencer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned OPERAND_BYTES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [7:0]                   i_rx_byte,
    input  logic                         i_rx_byte_valid,
    input  logic                         i_rx_err,
    output logic [7:0]                   o_cmd_op,
    output logic [8*OPERAND_BYTES-1:0]   o_cmd_operand,
    output logic                         o_cmd_valid,
    input  logic                         i_cmd_ready,
`ifdef UART_CMD_STATS_EN
    output logic [15:0]                  o_good_cnt,
    output logic [15:0]                  o_drop_cnt,
`endif
    output logic                         o_frame_err,
    output logic                         o_overrun
);

    localparam int unsigned OPW  = 8 * OPERAND_BYTES;
    localparam int unsigned IDXW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(OPERAND_BYTES - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_OPCODE  = 3'd1;
    localparam logic [2:0] ST_OPERAND = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_ISSUE   = 3'd4;

    logic [2:0]      state_q,     state_d;
    logic [7:0]      op_q,        op_d;
    logic [OPW-1:0]  operand_q,   operand_d;
    logic [7:0]      cks_q,       cks_d;
    logic [IDXW-1:0] idx_q,       idx_d;
    logic [TW-1:0]   tmo_q,       tmo_d;
    logic            valid_q,     valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q,   overrun_d;

    logic in_frame;
    logic abort;

    assign in_frame = (state_q == ST_OPCODE) || (state_q == ST_OPERAND) ||
                      (state_q == ST_CHECK);
    // Timeout outranks an rx error, which outranks a byte in the same cycle.
    assign abort    = in_frame && ((tmo_q == TMO_LAST) || i_rx_err);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_d   = operand_q;
        cks_d       = cks_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (!in_frame || abort || i_rx_byte_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (abort) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_byte_valid && (i_rx_byte == SYNC_BYTE)) begin
                        state_d = ST_OPCODE;
                    end
                end
                ST_OPCODE: begin
                    if (i_rx_byte_valid) begin
                        op_d    = i_rx_byte;
                        cks_d   = i_rx_byte;
                        idx_d   = '0;
                        state_d = ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    if (i_rx_byte_valid) begin
                        for (int b = 0; b < OPERAND_BYTES; b++) begin
                            if (idx_q == IDXW'(b)) begin
                                operand_d[8*b +: 8] = i_rx_byte;
                            end
                        end
                        cks_d = cks_q ^ i_rx_byte;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_rx_byte_valid) begin
                        if (i_rx_byte == cks_q) begin
                            valid_d = 1'b1;
                            state_d = ST_ISSUE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Bytes here are dropped outright, never treated as SYNC.
                    overrun_d = i_rx_byte_valid;
                    if (i_cmd_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    op_d      = '0;
                    operand_d = '0;
                    cks_d     = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            operand_q   <= '0;
            cks_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            cks_q       <= cks_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_cmd_op      = op_q;
    assign o_cmd_operand = operand_q;
    assign o_cmd_valid   = valid_q;
    assign o_frame_err   = frame_err_q;
    assign o_overrun     = overrun_q;

`ifdef UART_CMD_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (valid_q && i_cmd_ready && (good_cnt_q != 16'hFFFF)) begin
            good_cnt_d = good_cnt_q + 16'd1;
        end
        if ((frame_err_q || overrun_q) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_good_cnt = good_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire
